muldiv_unit: RTL and testbench

Iterative multiply/divide unit for the EX stage of the 5-stage MIPS pipeline. It sits beside the ALU, downstream of the ID/EX register, and owns the architectural HI/LO registers. It executes MULT, MULTU, DIV, DIVU, MTHI and MTLO. While a multi-cycle operation runs, it holds `busy` high so the hazard logic stalls IF/ID and ID/EX. HI/LO values go to the EX-stage result mux for MFHI/MFLO.

---
 rtl/mips_pkg.sv | 37 +++
 rtl/muldiv_unit_if.sv | 19 +
 rtl/muldiv_datapath.sv | 57 +++++
 rtl/muldiv_unit.sv | 144 ++++++++++++++
 tb/tb_muldiv_unit.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared op codes, FSM states and sizing helpers for the EX-stage multiply/divide unit.
package mips_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } muldiv_state_t;

    function automatic int cntWidth(input int width);
        return $clog2(width) + 1;
    endfunction

    localparam int CNT_W = cntWidth(XLEN);

    function automatic logic isIterOp(input logic [2:0] op);
        return (op[2] == 1'b0);
    endfunction

    function automatic logic isDivOp(input logic [2:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic isSignedOp(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Issue/result bundle between the EX stage and the multiply/divide unit.
interface muldiv_unit_if
    import mips_pkg::*;
#(
    parameter int WIDTH = XLEN
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (output start, op, a, b, flush, input busy, done, hi, lo);
    modport slave  (input start, op, a, b, flush, output busy, done, hi, lo);
endinterface

// File: rtl/muldiv_datapath.sv
// Iteration registers and the shared adder/subtractor for shift-add multiply
// and restoring divide on unsigned magnitudes.
module muldiv_datapath
    import mips_pkg::*;
#(
    parameter int WIDTH = XLEN
)
(
    input  logic               clk,
    input  logic               rst,
    input  logic               i_init,
    input  logic               i_step,
    input  logic               i_isDiv,
    input  logic [WIDTH-1:0]   i_absA,
    input  logic [WIDTH-1:0]   i_absB,
    output logic [2*WIDTH-1:0] o_prod,
    output logic [WIDTH-1:0]   o_quot,
    output logic [WIDTH-1:0]   o_rem
);
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH:0]   w_shifted;
    logic [WIDTH:0]   w_addend;
    logic [WIDTH:0]   w_addSub;

    // Divide subtracts the divisor from the shifted remainder; multiply adds
    // the multiplicand when the current multiplier bit is set.
    assign w_shifted = {r_hi, r_lo[WIDTH-1]};
    assign w_addend  = r_lo[0] ? {1'b0, r_b} : '0;
    assign w_addSub  = i_isDiv ? (w_shifted - {1'b0, r_b}) : ({1'b0, r_hi} + w_addend);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hi <= '0;
            r_lo <= '0;
            r_b  <= '0;
        end else if (i_init) begin
            r_hi <= '0;
            r_lo <= i_absA;
            r_b  <= i_absB;
        end else if (i_step) begin
            if (i_isDiv) begin
                r_hi <= w_addSub[WIDTH] ? w_shifted[WIDTH-1:0] : w_addSub[WIDTH-1:0];
                r_lo <= {r_lo[WIDTH-2:0], ~w_addSub[WIDTH]};
            end else begin
                r_hi <= w_addSub[WIDTH:1];
                r_lo <= {w_addSub[0], r_lo[WIDTH-1:1]};
            end
        end
    end

    assign o_prod = {r_hi, r_lo};
    assign o_quot = r_lo;
    assign o_rem  = r_hi;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU/MTHI/MTLO unit owning the HI/LO registers;
// holds busy while an operation iterates so the front of the pipe stalls.
module muldiv_unit
    import mips_pkg::*;
#(
    parameter int WIDTH = XLEN
)
(
    input  logic         clk,
    input  logic         rst,
    muldiv_unit_if.slave bus
);
    localparam int CW = cntWidth(WIDTH);

    muldiv_state_t      r_state;
    muldiv_state_t      w_nextState;
    logic [CW-1:0]      r_cnt;
    logic               r_isDiv;
    logic               r_isSigned;
    logic               r_signA;
    logic               r_signB;
    logic               r_divZero;
    logic [WIDTH-1:0]   r_rawA;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;
    logic               w_busy;
    logic               w_accept;
    logic               w_step;
    logic               w_lastIter;
    logic               w_opSigned;
    logic [WIDTH-1:0]   w_absA;
    logic [WIDTH-1:0]   w_absB;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prodFix;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_quotFix;
    logic [WIDTH-1:0]   w_remFix;
    logic [WIDTH-1:0]   w_resHi;
    logic [WIDTH-1:0]   w_resLo;

    assign w_opSigned = isSignedOp(bus.op);
    assign w_accept   = (r_state == ST_IDLE) && bus.start && !bus.flush && isIterOp(bus.op);
    assign w_step     = (r_state == ST_CALC) && !bus.flush;
    assign w_lastIter = (r_cnt == CW'(WIDTH - 1));
    assign w_absA     = (w_opSigned && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    assign w_absB     = (w_opSigned && bus.b[WIDTH-1]) ? -bus.b : bus.b;

    muldiv_datapath #(.WIDTH(WIDTH)) u_datapath (
        .clk     (clk),
        .rst     (rst),
        .i_init  (w_accept),
        .i_step  (w_step),
        .i_isDiv (r_isDiv),
        .i_absA  (w_absA),
        .i_absB  (w_absB),
        .o_prod  (w_prod),
        .o_quot  (w_quot),
        .o_rem   (w_rem)
    );

    always_comb begin
        w_nextState = r_state;
        w_busy      = (r_state != ST_IDLE);
        if (bus.flush) begin
            w_nextState = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (w_accept) w_nextState = ST_CALC;
                ST_CALC: if (w_lastIter) w_nextState = ST_FIX;
                ST_FIX:  w_nextState = ST_IDLE;
                default: w_nextState = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_done     <= 1'b0;
            r_cnt      <= '0;
            r_isDiv    <= 1'b0;
            r_isSigned <= 1'b0;
            r_signA    <= 1'b0;
            r_signB    <= 1'b0;
            r_divZero  <= 1'b0;
            r_rawA     <= '0;
        end else begin
            r_state <= w_nextState;
            r_done  <= (r_state == ST_FIX) && !bus.flush;
            if (w_accept) begin
                r_cnt      <= '0;
                r_isDiv    <= isDivOp(bus.op);
                r_isSigned <= w_opSigned;
                r_signA    <= w_opSigned && bus.a[WIDTH-1];
                r_signB    <= w_opSigned && bus.b[WIDTH-1];
                r_divZero  <= (bus.b == '0);
                r_rawA     <= bus.a;
            end else if (r_state == ST_CALC) begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    // Remainder follows the dividend's sign; a zero divisor bypasses fix-up entirely.
    always_comb begin
        w_prodFix = (r_isSigned && (r_signA ^ r_signB)) ? -w_prod : w_prod;
        w_quotFix = (r_isSigned && (r_signA ^ r_signB)) ? -w_quot : w_quot;
        w_remFix  = (r_isSigned && r_signA) ? -w_rem : w_rem;
        w_resHi   = w_prodFix[2*WIDTH-1:WIDTH];
        w_resLo   = w_prodFix[WIDTH-1:0];
        if (r_isDiv) begin
            if (r_divZero) begin
                w_resHi = r_rawA;
                w_resLo = '1;
            end else begin
                w_resHi = w_remFix;
                w_resLo = w_quotFix;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (!bus.flush) begin
            if (r_state == ST_FIX) begin
                r_hi <= w_resHi;
                r_lo <= w_resLo;
            end else if ((r_state == ST_IDLE) && bus.start) begin
                if (bus.op == OP_MTHI) r_hi <= bus.a;
                if (bus.op == OP_MTLO) r_lo <= bus.a;
            end
        end
    end

    assign bus.busy = w_busy;
    assign bus.done = r_done;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed corner cases plus random ops
// checked against a 64-bit arithmetic reference model.
module tb_muldiv_unit;
    import mips_pkg::*;

    localparam int W = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    int          checks = 0;
    int          errors = 0;
    int          doneCount = 0;
    logic [63:0] sbq[$];
    logic [63:0] monExp;
    logic [31:0] modelHi = '0;
    logic [31:0] modelLo = '0;

    muldiv_unit_if #(.WIDTH(W)) bus ();

    muldiv_unit #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    // HI:LO result computed with plain signed/unsigned 64-bit arithmetic.
    function automatic logic [63:0] refModel(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      q;
        longint      r;
        logic [63:0] ua;
        logic [63:0] ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            OP_MULT:  return 64'(sa * sb);
            OP_MULTU: return ua * ub;
            OP_DIV: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            OP_DIVU: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {32'(ua % ub), 32'(ua / ub)};
            end
            default: return {modelHi, modelLo};
        endcase
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst && bus.done) begin
            doneCount++;
            if (sbq.size() == 0) begin
                checkOutput("spurious_done", 64'(bus.done), 64'd0);
            end else begin
                monExp = sbq.pop_front();
                checkOutput("result_hi", 64'(bus.hi), 64'(monExp[63:32]));
                checkOutput("result_lo", 64'(bus.lo), 64'(monExp[31:0]));
            end
        end
    end

    // Called on a falling edge; returns on the falling edge after busy drops.
    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int          busyCycles;
        logic [63:0] res;
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        if (op <= OP_DIVU) begin
            res = refModel(op, a, b);
            sbq.push_back(res);
            modelHi = res[63:32];
            modelLo = res[31:0];
        end else if (op == OP_MTHI) begin
            modelHi = a;
        end else if (op == OP_MTLO) begin
            modelLo = a;
        end
        @(negedge clk);
        bus.start  = 1'b0;
        bus.a      = $urandom();
        bus.b      = $urandom();
        busyCycles = 0;
        while (bus.busy && busyCycles < 100) begin
            busyCycles++;
            @(negedge clk);
        end
        checkOutput("busy_cycles", 64'(busyCycles), (op <= OP_DIVU) ? 64'd33 : 64'd0);
        if (op > OP_DIVU) begin
            checkOutput("hi_after_op", 64'(bus.hi), 64'(modelHi));
            checkOutput("lo_after_op", 64'(bus.lo), 64'(modelLo));
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation still running at time %0t, required to finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          savedDone;
        logic [2:0]  rOp;
        logic [31:0] rA;
        logic [31:0] rB;

        bus.start = 1'b0;
        bus.op    = OP_MULT;
        bus.a     = '0;
        bus.b     = '0;
        bus.flush = 1'b0;

        repeat (3) @(negedge clk);
        checkOutput("reset_hi",   64'(bus.hi),   64'd0);
        checkOutput("reset_lo",   64'(bus.lo),   64'd0);
        checkOutput("reset_busy", 64'(bus.busy), 64'd0);
        checkOutput("reset_done", 64'(bus.done), 64'd0);
        rst = 1'b1;
        @(negedge clk);

        applyStimulus(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        applyStimulus(OP_MULT,  32'hFFFF_FFFD, 32'd5);
        applyStimulus(OP_DIV,   32'hFFFF_FFF9, 32'd2);
        applyStimulus(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF);
        applyStimulus(OP_DIVU,  32'd100,       32'd0);
        applyStimulus(OP_DIV,   32'hFFFF_FFF7, 32'd0);
        applyStimulus(OP_DIV,   32'd7,         32'hFFFF_FFFE);
        applyStimulus(OP_MTLO,  32'hCAFE_F00D, 32'd0);
        applyStimulus(3'd6,     32'h1111_1111, 32'd0);

        // Flush at cycle 10 of a multiply: no done, HI/LO keep their old values.
        applyStimulus(OP_MTHI, 32'h1234_5678, 32'd0);
        bus.start = 1'b1;
        bus.op    = OP_MULTU;
        bus.a     = 32'd2;
        bus.b     = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        checkOutput("flush_busy", 64'(bus.busy), 64'd0);
        savedDone = doneCount;
        repeat (40) @(negedge clk);
        checkOutput("flush_no_done", 64'(doneCount), 64'(savedDone));
        checkOutput("flush_hi", 64'(bus.hi), 64'h1234_5678);
        checkOutput("flush_lo", 64'(bus.lo), 64'(modelLo));
        applyStimulus(OP_MULTU, 32'd2, 32'd3);

        // Start in the same cycle as flush is dropped, for both kinds of op.
        bus.start = 1'b1;
        bus.flush = 1'b1;
        bus.op    = OP_MTLO;
        bus.a     = 32'hAAAA_5555;
        @(negedge clk);
        bus.op = OP_DIVU;
        @(negedge clk);
        bus.start = 1'b0;
        bus.flush = 1'b0;
        checkOutput("flush_start_busy", 64'(bus.busy), 64'd0);
        checkOutput("flush_start_lo",   64'(bus.lo),   64'(modelLo));

        // A start presented while busy must not disturb the running divide.
        bus.start = 1'b1;
        bus.op    = OP_DIVU;
        bus.a     = 32'd1000;
        bus.b     = 32'd7;
        sbq.push_back(refModel(OP_DIVU, 32'd1000, 32'd7));
        modelHi = 32'd6;
        modelLo = 32'd142;
        @(negedge clk);
        bus.op = OP_MTHI;
        bus.a  = 32'hDEAD_BEEF;
        repeat (3) @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < 100 && bus.busy; i++) @(negedge clk);
        checkOutput("busy_start_hi", 64'(bus.hi), 64'(modelHi));
        checkOutput("busy_start_lo", 64'(bus.lo), 64'(modelLo));

        // Asynchronous reset in the middle of a divide.
        bus.start = 1'b1;
        bus.op    = OP_DIV;
        bus.a     = 32'hFFFF_0001;
        bus.b     = 32'd13;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (14) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("midreset_hi",   64'(bus.hi),   64'd0);
        checkOutput("midreset_lo",   64'(bus.lo),   64'd0);
        checkOutput("midreset_busy", 64'(bus.busy), 64'd0);
        checkOutput("midreset_done", 64'(bus.done), 64'd0);
        modelHi = '0;
        modelLo = '0;
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(OP_MULTU, 32'd7, 32'd9);

        for (int n = 0; n < 40; n++) begin
            rOp = 3'($urandom_range(0, 7));
            rA  = $urandom();
            rB  = $urandom();
            case ($urandom_range(0, 7))
                0: rB = 32'd0;
                1: begin rA = 32'h8000_0000; rB = 32'hFFFF_FFFF; end
                2: rB = 32'($urandom_range(1, 15));
                3: rB = -32'($urandom_range(1, 15));
                default: ;
            endcase
            applyStimulus(rOp, rA, rB);
        end

        repeat (3) @(negedge clk);
        checkOutput("scoreboard_empty", 64'(sbq.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
